// File: rtl/ip_header_rx_if.sv
// Byte stream carrying a received Ethernet frame into the IPv4 header parser.
interface ip_header_rx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       eth_header_done;

  modport master (output data_in, data_valid, eth_header_done);
  modport slave  (input  data_in, data_valid, eth_header_done);
endinterface

// File: rtl/ip_header_rx.sv
// IPv4 header parser: checks checksum, protocol, fragmentation, destination and
// length of a 20-byte header, and reports the source address and total length.
module ip_header_rx (
  input  logic          aclk,
  input  logic          aresetn,
  ip_header_rx_if.slave rx,
  input  logic [31:0]   ip_d,
  output logic [31:0]   ip_s,
  output logic [15:0]   ip_total_len,
  output logic          ip_header_done,
  output logic          ip_header_valid
);

  typedef enum logic [1:0] {WAIT, HEADER, DROP} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [15:0] acc_reg, acc_next;
  logic [7:0]  hi_reg, hi_next;
  logic        ok_reg, ok_next;
  logic [31:0] ip_s_reg, ip_s_next;
  logic [15:0] len_reg, len_next;
  logic        done_reg, done_next;
  logic        valid_reg, valid_next;

  logic [15:0] word;
  logic [16:0] sum17;
  logic [15:0] acc_fold;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= WAIT;
      cnt_reg   <= 5'd0;
      acc_reg   <= 16'd0;
      hi_reg    <= 8'd0;
      ok_reg    <= 1'b0;
      ip_s_reg  <= 32'd0;
      len_reg   <= 16'd0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      hi_reg    <= hi_next;
      ok_reg    <= ok_next;
      ip_s_reg  <= ip_s_next;
      len_reg   <= len_next;
      done_reg  <= done_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    hi_next    = hi_reg;
    ok_next    = ok_reg;
    ip_s_next  = ip_s_reg;
    len_next   = len_reg;
    done_next  = 1'b0;
    valid_next = valid_reg;

    // Even bytes are held as the high half; odd bytes complete a word and fold it in.
    word     = {hi_reg, rx.data_in};
    sum17    = {1'b0, acc_reg} + {1'b0, word};
    acc_fold = sum17[15:0] + {15'd0, sum17[16]};

    if (!rx.data_valid) begin
      state_next = WAIT;
      cnt_next   = 5'd0;
      acc_next   = 16'd0;
      valid_next = 1'b0;
    end else if (rx.eth_header_done) begin
      // A new frame start always wins, even mid-header or while dropping.
      acc_next   = 16'd0;
      hi_next    = rx.data_in;
      ok_next    = 1'b1;
      valid_next = 1'b0;
      if (rx.data_in == 8'h45) begin
        state_next = HEADER;
        cnt_next   = 5'd1;
      end else begin
        state_next = DROP;
        cnt_next   = 5'd0;
      end
    end else if (state_reg == HEADER) begin
      cnt_next = cnt_reg + 5'd1;
      if (cnt_reg[0]) acc_next = acc_fold;
      else            hi_next  = rx.data_in;
      case (cnt_reg)
        5'd2:  len_next[15:8]   = rx.data_in;
        5'd3:  len_next[7:0]    = rx.data_in;
        5'd6:  if (rx.data_in[5:0] != 6'd0)    ok_next = 1'b0;
        5'd7:  if (rx.data_in != 8'd0)         ok_next = 1'b0;
        5'd9:  if (rx.data_in != 8'h11)        ok_next = 1'b0;
        5'd12: ip_s_next[31:24] = rx.data_in;
        5'd13: ip_s_next[23:16] = rx.data_in;
        5'd14: ip_s_next[15:8]  = rx.data_in;
        5'd15: ip_s_next[7:0]   = rx.data_in;
        5'd16: if (rx.data_in != ip_d[31:24]) ok_next = 1'b0;
        5'd17: if (rx.data_in != ip_d[23:16]) ok_next = 1'b0;
        5'd18: if (rx.data_in != ip_d[15:8])  ok_next = 1'b0;
        5'd19: begin
          state_next = WAIT;
          cnt_next   = 5'd0;
          acc_next   = 16'd0;
          done_next  = 1'b1;
          valid_next = ok_reg && (rx.data_in == ip_d[7:0]) &&
                       (acc_fold == 16'hFFFF) && (len_reg >= 16'd28);
        end
        default: ;
      endcase
    end
  end

  assign ip_s            = ip_s_reg;
  assign ip_total_len    = len_reg;
  assign ip_header_done  = done_reg;
  assign ip_header_valid = valid_reg;

endmodule

// File: tb/tb_ip_header_rx.sv
// Self-checking bench for ip_header_rx: directed header table plus randomized
// headers scored against a checksum/field reference model.
module tb_ip_header_rx;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] ip_d;
  logic [31:0] ip_s;
  logic [15:0] ip_total_len;
  logic        ip_header_done;
  logic        ip_header_valid;

  ip_header_rx_if rx_bus ();

  ip_header_rx dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .rx              (rx_bus),
    .ip_d            (ip_d),
    .ip_s            (ip_s),
    .ip_total_len    (ip_total_len),
    .ip_header_done  (ip_header_done),
    .ip_header_valid (ip_header_valid)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;
  int done_count = 0;

  always @(negedge aclk) if (ip_header_done === 1'b1) done_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [159:0] hdr;
    logic [31:0]  ipd;
    int           nbytes;
    logic         exp_done;
    logic         exp_valid;
  } vec_t;

  localparam logic [159:0] GOOD = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;

  function automatic logic [7:0] hbyte(input logic [159:0] h, input int i);
    return h[159-8*i -: 8];
  endfunction

  // Ones'-complement sum of the ten words, carries folded once at the end.
  function automatic logic [15:0] ones_sum(input logic [159:0] h);
    logic [31:0] s;
    s = 0;
    for (int w = 0; w < 10; w++) s += {16'd0, h[159-16*w -: 16]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  function automatic logic [159:0] fix_csum(input logic [159:0] h);
    logic [159:0] t;
    t = h;
    t[79:64] = 16'd0;
    t[79:64] = ~ones_sum(t);
    return t;
  endfunction

  function automatic logic model_valid(input logic [159:0] h, input logic [31:0] ipd);
    return (hbyte(h, 0) == 8'h45) && (ones_sum(h) == 16'hFFFF) &&
           (hbyte(h, 9) == 8'h11) && ((hbyte(h, 6) & 8'h3F) == 8'd0) &&
           (hbyte(h, 7) == 8'd0) && (h[31:0] == ipd) && (h[143:128] >= 16'd28);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] b, input logic v, input logic sof);
    rx_bus.data_in         = b;
    rx_bus.data_valid      = v;
    rx_bus.eth_header_done = sof;
    @(posedge aclk);
    #1;
  endtask

  task automatic frame(input logic [159:0] hdr, input int nbytes, input logic exp_done,
                       input logic exp_valid, input string tag);
    int d0;
    d0 = done_count;
    for (int i = 0; i < nbytes; i++) begin
      step(hbyte(hdr, i), 1'b1, i == 0);
      if (i == 19) begin
        check({tag, " done"}, {31'd0, ip_header_done}, {31'd0, exp_done});
        if (exp_done) begin
          check({tag, " valid"}, {31'd0, ip_header_valid}, {31'd0, exp_valid});
          check({tag, " ip_s"}, ip_s, hdr[63:32]);
          check({tag, " len"}, {16'd0, ip_total_len}, {16'd0, hdr[143:128]});
        end
      end
    end
    if (nbytes == 20) begin
      step(8'($urandom), 1'b1, 1'b0);
      check({tag, " done width"}, {31'd0, ip_header_done}, 32'd0);
      step(8'($urandom), 1'b1, 1'b0);
      check({tag, " valid held"}, {31'd0, ip_header_valid}, {31'd0, exp_valid});
    end
    step(8'd0, 1'b0, 1'b0);
    check({tag, " valid clr"}, {31'd0, ip_header_valid}, 32'd0);
    if (exp_done) check({tag, " ip_s hold"}, ip_s, hdr[63:32]);
    step(8'd0, 1'b0, 1'b0);
    check({tag, " done count"}, done_count - d0, {31'd0, exp_done});
    $display("[TB] frame %s bytes=%0d exp_done=%0d exp_valid=%0d ip_s=%h len=%h",
             tag, nbytes, exp_done, exp_valid, ip_s, ip_total_len);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{GOOD, 32'hC0A800C7, 20, 1'b1, 1'b1};
    vecs[1] = '{160'h4500_0073_0000_4000_4011_B862_C0A8_0001_C0A8_00C7, 32'hC0A800C7, 20, 1'b1, 1'b0};
    vecs[2] = '{160'h4600_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7, 32'hC0A800C7, 20, 1'b0, 1'b0};
    vecs[3] = '{GOOD, 32'hC0A800C7, 20, 1'b1, 1'b1};
    vecs[4] = '{160'h4500_0073_0000_4000_4006_B861_C0A8_0001_C0A8_00C7, 32'hC0A800C7, 20, 1'b1, 1'b0};
    vecs[5] = '{160'h4500_0073_0000_2000_4011_B861_C0A8_0001_C0A8_00C7, 32'hC0A800C7, 20, 1'b1, 1'b0};
    vecs[6] = '{GOOD, 32'hC0A800C8, 20, 1'b1, 1'b0};
    vecs[7] = '{GOOD, 32'hC0A800C7, 10, 1'b0, 1'b0};
    vecs[8] = '{160'h4500_0014_0000_4000_4011_B8C0_C0A8_0001_C0A8_00C7, 32'hC0A800C7, 20, 1'b1, 1'b0};
    vecs[9] = '{160'h4500_001C_0000_4000_4011_B8B8_C0A8_0001_C0A8_00C7, 32'hC0A800C7, 20, 1'b1, 1'b1};

    aresetn                = 1'b0;
    ip_d                   = 32'hC0A800C7;
    rx_bus.data_in         = 8'd0;
    rx_bus.data_valid      = 1'b0;
    rx_bus.eth_header_done = 1'b0;
    repeat (3) step(8'd0, 1'b0, 1'b0);
    check("reset ip_s", ip_s, 32'd0);
    check("reset len", {16'd0, ip_total_len}, 32'd0);
    check("reset done", {31'd0, ip_header_done}, 32'd0);
    check("reset valid", {31'd0, ip_header_valid}, 32'd0);
    aresetn = 1'b1;
    repeat (2) step(8'd0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      ip_d = vecs[k].ipd;
      frame(vecs[k].hdr, vecs[k].nbytes, vecs[k].exp_done, vecs[k].exp_valid, $sformatf("vec%0d", k));
    end

    // New eth_header_done mid-header restarts parsing without a gap.
    ip_d = 32'hC0A800C7;
    for (int i = 0; i < 8; i++) step(hbyte(GOOD, i) ^ 8'h5A, 1'b1, i == 0);
    frame(GOOD, 20, 1'b1, 1'b1, "restart");

    // Asynchronous reset in the middle of the header.
    for (int i = 0; i < 15; i++) step(hbyte(GOOD, i), 1'b1, i == 0);
    begin
      int d0;
      d0 = done_count;
      #2 aresetn = 1'b0;
      #1;
      check("async rst ip_s", ip_s, 32'd0);
      check("async rst len", {16'd0, ip_total_len}, 32'd0);
      check("async rst valid", {31'd0, ip_header_valid}, 32'd0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      for (int i = 15; i < 20; i++) step(hbyte(GOOD, i), 1'b1, 1'b0);
      step(8'd0, 1'b1, 1'b0);
      check("post rst no done", done_count - d0, 32'd0);
      step(8'd0, 1'b0, 1'b0);
    end
    frame(GOOD, 20, 1'b1, 1'b1, "post_rst");

    for (int r = 0; r < 40; r++) begin
      logic [159:0] h;
      logic [31:0]  ipd_r;
      int           nb;
      int           m;
      logic         ed;
      logic         ev;
      ipd_r = $urandom;
      h = {8'h45, 8'h00, 16'(28 + $urandom_range(0, 1400)), 16'($urandom), 16'h4000,
           8'h40, 8'h11, 16'h0000, 32'($urandom), ipd_r};
      m = $urandom_range(0, 9);
      case (m)
        0: h[159:152] = 8'h46;
        1: h[87:80]   = 8'h06;
        2: h[111:104] = 8'h20;
        3: h[103:96]  = 8'($urandom_range(1, 255));
        4: h[143:128] = 16'($urandom_range(0, 27));
        5: h[0]       = ~h[0];
        default: ;
      endcase
      h = fix_csum(h);
      if (m == 6) h[64] = ~h[64];
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 19)) : 20;
      ed = (nb == 20) && (hbyte(h, 0) == 8'h45);
      ev = ed && model_valid(h, ipd_r);
      ip_d = ipd_r;
      frame(h, nb, ed, ev, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ip_header_rx.md
IP_HEADER_RX -- requirements
Module: ip_header_rx

Interface
REQ-001 SHALL have port aclk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-002 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port data_in, input, 8, the received frame byte, sampled when data_valid=1.
REQ-004 SHALL have port data_valid, input, 1, frame-active qualifier, high for every byte of a frame.
REQ-005 SHALL have port eth_header_done, input, 1, a one-cycle pulse coincident with IP header byte 0 on data_in.
REQ-006 SHALL have port ip_d, input, 32, the local IPv4 address, static during a frame.
REQ-007 SHALL have port ip_s, output, 32, the captured source IPv4 address.
REQ-008 SHALL have port ip_total_len, output, 16, the captured IPv4 Total Length field.
REQ-009 SHALL have port ip_header_done, output, 1, a one-cycle pulse coincident with the first byte after the header (UDP byte 0).
REQ-010 SHALL have port ip_header_valid, output, 1, header-accepted qualifier for the current frame.

Function
REQ-011 SHALL implement states WAIT, HEADER and DROP with a 5-bit byte counter (0..19).
REQ-012 In WAIT, eth_header_done=1 with data_valid=1 SHALL treat data_in as byte 0 and go to HEADER with counter=1, or go to DROP if data_in!=8'h45.
REQ-013 In HEADER, each cycle with data_valid=1 SHALL consume one byte and increment the counter; byte 19 SHALL return to WAIT with counter=0.
REQ-014 Byte map: bytes 2-3 -> ip_total_len (MSB first); byte 6 bits[5:0] and byte 7 = MF flag and fragment offset; byte 9 = protocol; bytes 12-15 -> ip_s (MSB first); bytes 16-19 = destination address.
REQ-015 The checksum SHALL be the 16-bit ones'-complement sum of the ten big-endian header words, with end-around carry folded after each word (17-bit accumulate, fold); it passes iff the final sum is 16'hFFFF.
REQ-016 The header SHALL be accepted iff checksum passes, protocol=8'h11, (byte6&8'h3F)=0, byte7=0, destination={bytes16..19}=ip_d, and ip_total_len>=16'd28.
REQ-017 ip_header_done SHALL be registered high for exactly the one cycle after byte 19 is consumed, whether or not the header is accepted.
REQ-018 ip_header_valid SHALL be set with ip_header_done to the REQ-016 result and held until data_valid=0 or the next eth_header_done.
REQ-019 ip_s and ip_total_len SHALL update as their bytes arrive and hold until overwritten by the next frame.
REQ-020 data_valid=0 in any state SHALL return synchronously to WAIT next cycle, clearing counter, checksum accumulator and ip_header_valid, with no ip_header_done.
REQ-021 DROP SHALL ignore data until data_valid=0, then go to WAIT; no ip_header_done is issued.
REQ-022 eth_header_done while in HEADER or DROP SHALL restart parsing as in REQ-012 (the new frame wins).
REQ-023 Latency: header byte 19 on cycle N -> ip_header_done and final ip_header_valid on cycle N+1.

Reset
REQ-024 aresetn=0 SHALL asynchronously force state=WAIT, counter=0, accumulator=0, ip_s=0, ip_total_len=0, ip_header_done=0, ip_header_valid=0.
REQ-025 Reset release SHALL take effect on the next aclk edge; parsing starts only on a later eth_header_done.

Verification
REQ-026 Header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, ip_d=C0A800C7 -> one-cycle done, valid=1, ip_s=C0A80001, ip_total_len=0073.
REQ-027 Same header with byte 11 = 62 -> done pulse, valid=0.
REQ-028 Byte 0 = 46 -> DROP, no done; next good frame after data_valid low -> done with valid=1.
REQ-029 Good header with byte 9=06 or byte 6=20 (MF set) or ip_d=C0A800C8 -> done, valid=0.
REQ-030 data_valid low at byte 10, then good frame -> no done for the first frame, done with valid=1 for the second.
REQ-031 aresetn low at byte 15 -> all outputs 0 immediately; no done until a fresh eth_header_done.
